bm_buf_alloc: RTL

Buffer allocator and free-list manager for the buffer manager (bm). Holds every free buffer pointer in a circular RAM queue. Grants pointers to allocation requests, reclaims pointers returned by the buffer-release block on `rel_buf_valid`, and tracks per-port buffer occupancy. After reset it initialises the free list and, for each pointer, drives the `init_read_count_*` pulse that clears that buffer's release counter.

---
 rtl/bm_buf_alloc.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/bm_buf_alloc.sv
`default_nettype none

`ifndef BUF_PTR_NBITS
`define BUF_PTR_NBITS 4
`endif
`ifndef PORT_ID_NBITS
`define PORT_ID_NBITS 2
`endif

// +----------------------------------------------------------------------+
// | Module : bm_buf_alloc                                                |
// | Brief  : Free-list buffer allocator with per-port occupancy counts.  |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module bm_buf_alloc #(
    parameter int BUF_PTR_NBITS = `BUF_PTR_NBITS,
    parameter int PORT_ID_NBITS = `PORT_ID_NBITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_req,
    input  logic [PORT_ID_NBITS-1:0] alloc_req_port_id,
    output logic                     alloc_ack,
    output logic                     alloc_fail,
    output logic [BUF_PTR_NBITS-1:0] alloc_buf_ptr,
    output logic [PORT_ID_NBITS-1:0] alloc_port_id,
    input  logic                     rel_buf_valid,
    input  logic [PORT_ID_NBITS-1:0] rel_buf_port_id,
    input  logic [BUF_PTR_NBITS-1:0] rel_buf_ptr,
    output logic                     init_read_count_valid,
    output logic [BUF_PTR_NBITS-1:0] init_read_count_ptr,
    output logic                     init_done,
    output logic [BUF_PTR_NBITS:0]   free_count,
    input  logic [PORT_ID_NBITS-1:0] port_cnt_port_id,
    output logic [BUF_PTR_NBITS:0]   port_cnt,
    output logic                     rel_err
);

    localparam int                     c_num_bufs  = 1 << BUF_PTR_NBITS;
    localparam int                     c_num_ports = 1 << PORT_ID_NBITS;
    localparam logic [BUF_PTR_NBITS:0] c_full      = {1'b1, {BUF_PTR_NBITS{1'b0}}};
    localparam logic [BUF_PTR_NBITS:0] c_cnt_one   = {{BUF_PTR_NBITS{1'b0}}, 1'b1};
    localparam logic [BUF_PTR_NBITS-1:0] c_ptr_one = {{(BUF_PTR_NBITS-1){1'b0}}, 1'b1};

    localparam logic [0:0] c_st_init = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

    logic [0:0]               r_state;
    logic [0:0]               w_state_nxt;
    logic [BUF_PTR_NBITS-1:0] r_init_cnt;
    logic [BUF_PTR_NBITS-1:0] r_head;
    logic [BUF_PTR_NBITS-1:0] r_tail;
    logic [BUF_PTR_NBITS:0]   r_port_cnt [c_num_ports];
    logic [BUF_PTR_NBITS-1:0] r_mem [c_num_bufs];
    logic [BUF_PTR_NBITS-1:0] r_rd_data;
    logic                     r_s1_valid;
    logic                     r_s1_fail;
    logic [PORT_ID_NBITS-1:0] r_s1_port;

    logic                     w_run;
    logic                     w_alloc_ok;
    logic                     w_rel_ok;
    logic                     w_wr_en;
    logic [BUF_PTR_NBITS-1:0] w_wr_addr;
    logic [BUF_PTR_NBITS-1:0] w_wr_data;

    assign w_run      = (r_state == c_st_run);
    assign w_alloc_ok = w_run && alloc_req && (free_count != '0);
    assign w_rel_ok   = w_run && rel_buf_valid && (free_count != c_full) &&
                        (r_port_cnt[rel_buf_port_id] != '0);

    // The RAM write port is shared by list initialisation and releases.
    assign w_wr_en   = !w_run || w_rel_ok;
    assign w_wr_addr = w_run ? r_tail : r_init_cnt;
    assign w_wr_data = w_run ? rel_buf_ptr : r_init_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_init;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == c_st_init && r_init_cnt == '1) begin
            w_state_nxt = c_st_run;
        end
    end

    // Same-edge write to the head slot is forwarded so a read never sees stale data.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
        r_rd_data <= (w_rel_ok && r_tail == r_head) ? rel_buf_ptr : r_mem[r_head];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_init_cnt            <= '0;
            r_head                <= '0;
            r_tail                <= '0;
            r_s1_valid            <= 1'b0;
            r_s1_fail             <= 1'b0;
            r_s1_port             <= '0;
            alloc_ack             <= 1'b0;
            alloc_fail            <= 1'b0;
            alloc_buf_ptr         <= '0;
            alloc_port_id         <= '0;
            init_read_count_valid <= 1'b0;
            init_read_count_ptr   <= '0;
            init_done             <= 1'b0;
            free_count            <= '0;
            port_cnt              <= '0;
            rel_err               <= 1'b0;
        end else begin
            if (!w_run) begin
                r_init_cnt            <= r_init_cnt + c_ptr_one;
                init_read_count_valid <= 1'b1;
                init_read_count_ptr   <= r_init_cnt;
                free_count            <= free_count + c_cnt_one;
            end else begin
                init_read_count_valid <= 1'b0;
                init_done             <= 1'b1;
                if (w_alloc_ok) begin
                    r_head <= r_head + c_ptr_one;
                end
                if (w_rel_ok) begin
                    r_tail <= r_tail + c_ptr_one;
                end
                case ({w_alloc_ok, w_rel_ok})
                    2'b10:   free_count <= free_count - c_cnt_one;
                    2'b01:   free_count <= free_count + c_cnt_one;
                    default: free_count <= free_count;
                endcase
            end
            r_s1_valid    <= alloc_req;
            r_s1_fail     <= alloc_req && !w_alloc_ok;
            r_s1_port     <= alloc_req_port_id;
            alloc_ack     <= r_s1_valid;
            alloc_fail    <= r_s1_fail;
            alloc_buf_ptr <= r_rd_data;
            alloc_port_id <= r_s1_port;
            rel_err       <= rel_buf_valid && !w_rel_ok;
            port_cnt      <= r_port_cnt[port_cnt_port_id];
        end
    end

    generate
        for (genvar p = 0; p < c_num_ports; p++) begin : g_port
            logic w_inc;
            logic w_dec;
            assign w_inc = w_alloc_ok && (alloc_req_port_id == PORT_ID_NBITS'(p));
            assign w_dec = w_rel_ok && (rel_buf_port_id == PORT_ID_NBITS'(p));

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_port_cnt[p] <= '0;
                end else begin
                    case ({w_inc, w_dec})
                        2'b10:   r_port_cnt[p] <= r_port_cnt[p] + c_cnt_one;
                        2'b01:   r_port_cnt[p] <= r_port_cnt[p] - c_cnt_one;
                        default: r_port_cnt[p] <= r_port_cnt[p];
                    endcase
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire
